// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - 32-bit iterative radix-2 restoring divider (optional macro DIV_EARLY_OUT_EN)
module iter_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        div_signed,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  count;
    logic [63:0] part_rem;
    logic [31:0] divisor;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;

    logic        accept;
    logic        early_out;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [63:0] shifted;
    logic [32:0] diff;
    logic [63:0] step_rem;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept = in_valid & in_ready;
    assign abs1   = (div_signed & src1[31]) ? (~src1 + 32'd1) : src1;
    assign abs2   = (div_signed & src2[31]) ? (~src2 + 32'd1) : src2;

`ifdef DIV_EARLY_OUT_EN
    // Trivial cases (divide by zero, dividend smaller than divisor) need no iteration
    assign early_out = (src2 == 32'd0) || (abs1 < abs2);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step plus the sign fix-up applied to its result
    always_comb begin
        shifted  = {part_rem[62:0], 1'b0};
        diff     = {1'b0, shifted[63:32]} - {1'b0, divisor};
        step_rem = diff[32] ? shifted : {diff[31:0], shifted[31:1], 1'b1};
        if (div_zero)
            q_fix = 32'hFFFF_FFFF;
        else if (q_neg)
            q_fix = ~step_rem[31:0] + 32'd1;
        else
            q_fix = step_rem[31:0];
        // With a zero divisor the high half ends as |src1|, so this restores src1
        r_fix = r_neg ? (~step_rem[63:32] + 32'd1) : step_rem[63:32];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = early_out ? DONE : BUSY;
            BUSY:    if (count == 6'd1) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE) & ~flush;
        out_valid = (state == DONE);
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 6'd0;
            part_rem  <= 64'd0;
            divisor   <= 32'd0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
        end else if (accept) begin
            part_rem <= {32'd0, abs1};
            divisor  <= abs2;
            q_neg    <= (src1[31] ^ src2[31]) & div_signed;
            r_neg    <= src1[31] & div_signed;
            div_zero <= (src2 == 32'd0);
            count    <= 6'd32;
            if (early_out) begin
                quotient  <= (src2 == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                remainder <= src1;
            end
        end else if (state == BUSY && !flush) begin
            part_rem <= step_rem;
            count    <= count - 6'd1;
            // Last step: results land in the same edge that enters DONE
            if (count == 6'd1) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - randomized self-checking bench for iter_div_unit
module tb_iter_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        div_signed;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    iter_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_signed(div_signed),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
        logic [31:0] n;
        n = ~v + 32'd1;
        return (sgn && v[31]) ? n : v;
    endfunction

    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] eq;
        logic [31:0] er;
        logic        early;
        int          edges;
        int          exp_lat;
        model(sgn, a, b, eq, er);
        early = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        early = (b == 32'd0) || (mag(sgn, a) < mag(sgn, b));
`endif
        exp_lat = early ? 1 : 33;
        @(negedge clk);
        div_signed = sgn;
        src1       = a;
        src2       = b;
        in_valid   = 1'b1;
        check("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        src1       = $urandom;
        src2       = $urandom;
        div_signed = 1'($urandom_range(0, 1));
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", edges, exp_lat);
        if (!out_valid) return;
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_after_consume", out_valid, 1'b0);
        check("in_ready_after_consume", in_ready, 1'b1);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_signed = 1'b0;
        src1       = a;
        src2       = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        int          waited;

        reset      = 1'b1;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        div_signed = 1'b0;
        src1       = 32'd0;
        src2       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'd5, 32'd0, 0);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(1'b0, 32'd3, 32'd10, 0);
        run_op(1'b0, 32'd100, 32'd7, 5);

        // Flush ten cycles into an operation
        start_op(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        expect_silence("flush_no_result", 40);
        run_op(1'b0, 32'd9, 32'd4, 0);

        // Flush together with in_valid must not accept
        @(negedge clk);
        src1     = 32'd1000;
        src2     = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("flush_blocks_accept", in_ready, 1'b1);
        expect_silence("flush_accept_no_result", 40);

        // Flush in DONE with out_ready: result visible, then idle
        start_op(32'd9, 32'd4);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("flush_done_valid", out_valid, 1'b1);
        check("flush_done_quotient", quotient, 32'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("flush_done_cleared", out_valid, 1'b0);
        check("flush_done_in_ready", in_ready, 1'b1);

        // Reset mid-operation
        start_op(32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        reset = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1'b1);
        expect_silence("midreset_no_result", 40);

        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 20);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = -$urandom_range(1, 9);
                default: ;
            endcase
            run_op(sgn, a, b, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
